// File: rtl/reg_mux_stream.sv
// reg_mux_stream: N-channel stream multiplexer with a one-deep registered output.
// Mode 0 forwards the channel named by Select; Mode 1 arbitrates round-robin
// starting after the last granted channel. Optional transfer counter is built
// when the macro REG_MUX_STREAM_COUNT_EN is defined.
module reg_mux_stream #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int CHANNELS        = 4,
    parameter int BUS_WIDTH       = 2
) (
    input  logic                                Clock,
    input  logic                                Reset,
    input  logic [CHANNELS*INPUT_BIT_WIDTH-1:0] InputData,
    input  logic [CHANNELS-1:0]                 InputValid,
    output logic [CHANNELS-1:0]                 InputReady,
    input  logic [BUS_WIDTH-1:0]                Select,
    input  logic                                Mode,
    output logic [INPUT_BIT_WIDTH-1:0]          Output,
    output logic                                OutputValid,
    input  logic                                OutputReady,
    output logic [BUS_WIDTH-1:0]                OutputChannel
`ifdef REG_MUX_STREAM_COUNT_EN
    ,
    output logic [15:0]                         TransferCount
`endif
);

    // Registered output stage and round-robin pointer.
    logic [INPUT_BIT_WIDTH-1:0] out_data_q, out_data_d;
    logic [BUS_WIDTH-1:0]       out_chan_q, out_chan_d;
    logic                       out_valid_q, out_valid_d;
    logic [BUS_WIDTH-1:0]       ptr_q, ptr_d;

    // Arbitration results for the current cycle.
    logic                       grant_valid;
    logic [BUS_WIDTH-1:0]       grant_idx;
    logic [INPUT_BIT_WIDTH-1:0] grant_data;
    logic                       load_en;
    logic                       in_xfer;
    logic                       out_xfer;
    int                         rr_dist;
    int                         rr_best;

    // The output register may accept a word when empty or when being drained.
    assign load_en  = !out_valid_q || OutputReady;
    assign out_xfer = out_valid_q && OutputReady;
    assign in_xfer  = |InputReady;

    // Pick the granted channel: fixed Select in Mode 0, rotating priority in Mode 1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_dist     = 0;
        rr_best     = CHANNELS;
        if (!Mode) begin
            // Select values at or above CHANNELS never match a channel, so they grant nothing.
            for (int c = 0; c < CHANNELS; c++) begin
                if (int'(Select) == c && InputValid[c]) begin
                    grant_valid = 1'b1;
                    grant_idx   = BUS_WIDTH'(c);
                end
            end
        end else begin
            // Distance from Pointer+1, wrapped modulo CHANNELS; the nearest valid channel wins.
            for (int c = 0; c < CHANNELS; c++) begin
                rr_dist = c - int'(ptr_q) - 1;
                if (rr_dist < 0) rr_dist = rr_dist + CHANNELS;
                if (InputValid[c] && rr_dist < rr_best) begin
                    rr_best     = rr_dist;
                    grant_valid = 1'b1;
                    grant_idx   = BUS_WIDTH'(c);
                end
            end
        end
    end

    // Extract the granted channel's word from the packed input bus.
    always_comb begin
        grant_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(grant_idx) == c) grant_data = InputData[c*INPUT_BIT_WIDTH +: INPUT_BIT_WIDTH];
        end
    end

    // One-hot ready to the granted channel, only when the output can load and not in reset.
    always_comb begin
        InputReady = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            InputReady[c] = !Reset && grant_valid && load_en && (int'(grant_idx) == c);
        end
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (in_xfer) begin
                out_data_d  = grant_data;
                out_chan_d  = grant_idx;
                out_valid_d = 1'b1;
                if (Mode) ptr_d = grant_idx;
            end else begin
                // Drained with nothing new: word stays visible but is no longer valid.
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset; reset discards any held word.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (Reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= BUS_WIDTH'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign Output        = out_data_q;
    assign OutputChannel = out_chan_q;
    assign OutputValid   = out_valid_q;

`ifdef REG_MUX_STREAM_COUNT_EN
    logic [15:0] count_q, count_d;

    // Count output transfers; wraps naturally at 16 bits.
    always_comb begin
        count_d = count_q;
        if (out_xfer) count_d = count_q + 16'd1;
    end

    // Transfer counter register.
    always_ff @(posedge Clock) begin
        if (Reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign TransferCount = count_q;
`else
    // Without the counter the drain strobe has no consumer.
    logic unused_out_xfer;
    assign unused_out_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_reg_mux_stream.sv
// Self-checking bench for reg_mux_stream (4-channel main instance plus a
// 3-channel instance for the out-of-range Select case).
module tb_reg_mux_stream;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] InputData;
    logic [3:0]  InputValid;
    logic [3:0]  InputReady;
    logic [1:0]  Select;
    logic        Mode;
    logic [7:0]  Output;
    logic        OutputValid;
    logic        OutputReady;
    logic [1:0]  OutputChannel;

    logic [23:0] d3_data;
    logic [2:0]  d3_valid;
    logic [2:0]  d3_ready;
    logic [1:0]  d3_sel;
    logic [7:0]  d3_out;
    logic        d3_ovalid;
    logic [1:0]  d3_chan;

`ifdef REG_MUX_STREAM_COUNT_EN
    logic [15:0] TransferCount;
    logic [15:0] d3_count;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 Clock = ~Clock;

    reg_mux_stream #(.INPUT_BIT_WIDTH(8), .CHANNELS(4), .BUS_WIDTH(2)) u_dut (
        .Clock(Clock), .Reset(Reset), .InputData(InputData), .InputValid(InputValid),
        .InputReady(InputReady), .Select(Select), .Mode(Mode), .Output(Output),
        .OutputValid(OutputValid), .OutputReady(OutputReady), .OutputChannel(OutputChannel)
`ifdef REG_MUX_STREAM_COUNT_EN
        , .TransferCount(TransferCount)
`endif
    );

    reg_mux_stream #(.INPUT_BIT_WIDTH(8), .CHANNELS(3), .BUS_WIDTH(2)) u_dut3 (
        .Clock(Clock), .Reset(Reset), .InputData(d3_data), .InputValid(d3_valid),
        .InputReady(d3_ready), .Select(d3_sel), .Mode(1'b0), .Output(d3_out),
        .OutputValid(d3_ovalid), .OutputReady(1'b1), .OutputChannel(d3_chan)
`ifdef REG_MUX_STREAM_COUNT_EN
        , .TransferCount(d3_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [7:0] exp_out;
        logic [1:0] exp_chan;
    } sel_vec_t;

    sel_vec_t sel_tab[6];

    // Reference model state: the held word and the rotation origin.
    bit       m_valid;
    bit [7:0] m_data;
    int       m_chan;
    int       m_ptr;

    initial begin
        int       g;
        bit       load;
        bit       rst;
        bit [3:0] exp_ready;
        int       seq_a[6];
        int       seq_b[4];

        sel_tab[0] = '{2'd0, 8'd42, 2'd0};
        sel_tab[1] = '{2'd1, 8'd15, 2'd1};
        sel_tab[2] = '{2'd2, 8'd2,  2'd2};
        sel_tab[3] = '{2'd3, 8'd0,  2'd3};
        sel_tab[4] = '{2'd2, 8'd2,  2'd2};
        sel_tab[5] = '{2'd0, 8'd42, 2'd0};
        seq_a = '{0, 1, 2, 3, 0, 1};
        seq_b = '{1, 3, 1, 3};

        Reset       = 1'b1;
        InputData   = {8'd0, 8'd2, 8'd15, 8'd42};
        InputValid  = 4'hF;
        Select      = 2'd0;
        Mode        = 1'b0;
        OutputReady = 1'b1;
        d3_data     = {8'd2, 8'd15, 8'd42};
        d3_valid    = 3'b111;
        d3_sel      = 2'd0;

        // Reset state, with all inputs valid and the sink ready.
        tick();
        tick();
        check("rst_valid", OutputValid, 0);
        check("rst_out", Output, 0);
        check("rst_chan", OutputChannel, 0);
        check("rst_ready", InputReady, 0);
        check("rst3_ready", d3_ready, 0);
        check("rst3_valid", d3_ovalid, 0);

        // Fixed select stepped through channels, held for five cycles each.
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            Select = sel_tab[i].sel;
            for (int k = 0; k < 5; k++) begin
                tick();
                check("fix_out", Output, sel_tab[i].exp_out);
                check("fix_chan", OutputChannel, sel_tab[i].exp_chan);
                check("fix_valid", OutputValid, 1);
            end
        end

        // Round-robin with all channels valid: 0,1,2,3,0,1 after reset.
        Reset = 1'b1; Mode = 1'b1; InputData = {8'd44, 8'd33, 8'd22, 8'd11};
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_chan", OutputChannel, seq_a[i]);
            check("rr_valid", OutputValid, 1);
            check("rr_out", Output, 11 * (seq_a[i] + 1));
        end

        // Round-robin with only channels 1 and 3 valid.
        Reset = 1'b1; InputValid = 4'b1010;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr13_ready02", {InputReady[2], InputReady[0]}, 0);
            tick();
            check("rr13_chan", OutputChannel, seq_b[i]);
        end

        // Back-pressure: word 42 held while the sink stalls, then back-to-back load.
        Reset = 1'b1; Mode = 1'b0; Select = 2'd0; InputValid = 4'hF;
        InputData = {8'd0, 8'd2, 8'd15, 8'd42};
        tick();
        Reset = 1'b0;
        tick();
        check("bp_first", Output, 42);
        OutputReady = 1'b0; Select = 2'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_ready", InputReady, 0);
            tick();
            check("bp_out", Output, 42);
            check("bp_chan", OutputChannel, 0);
            check("bp_valid", OutputValid, 1);
        end
        OutputReady = 1'b1;
        #1;
        check("bp_release_ready", InputReady, 4'b0010);
        tick();
        check("bp_next_out", Output, 15);
        check("bp_next_chan", OutputChannel, 1);

        // Three-channel instance: Select=3 names no channel, so the output drains.
        d3_sel = 2'd0;
        tick();
        check("c3_out", d3_out, 42);
        check("c3_valid", d3_ovalid, 1);
        d3_sel = 2'd3;
        #1;
        check("c3_nogrant", d3_ready, 0);
        tick();
        check("c3_drained", d3_ovalid, 0);
        check("c3_retain", d3_out, 42);
        tick();
        check("c3_stays_empty", d3_ovalid, 0);

        // Randomized traffic against the reference model.
        Reset = 1'b1;
        tick();
        m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 3;
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 24) == 0);
            Reset       = rst;
            InputValid  = 4'($urandom);
            Mode        = 1'($urandom);
            Select      = 2'($urandom);
            OutputReady = ($urandom_range(0, 3) != 0);
            InputData   = $urandom;
            #1;
            load = !m_valid || OutputReady;
            g = -1;
            if (!Mode) begin
                if (InputValid[Select]) g = int'(Select);
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    if (g < 0 && InputValid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                end
            end
            exp_ready = (!rst && load && g >= 0) ? 4'(1 << g) : 4'b0;
            check("rnd_ready", InputReady, exp_ready);
            if (rst) begin
                m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 3;
            end else if (load) begin
                if (g >= 0) begin
                    m_valid = 1;
                    m_data  = InputData[g*8 +: 8];
                    m_chan  = g;
                    if (Mode) m_ptr = g;
                end else begin
                    m_valid = 0;
                end
            end
            tick();
            check("rnd_valid", OutputValid, m_valid);
            check("rnd_out", Output, m_data);
            check("rnd_chan", OutputChannel, m_chan);
        end

`ifdef REG_MUX_STREAM_COUNT_EN
        // Ten output transfers, then a one-cycle reset clears the counter.
        Reset = 1'b1; Mode = 1'b0; Select = 2'd0; InputValid = 4'hF; OutputReady = 1'b1;
        tick();
        Reset = 1'b0;
        check("cnt_rst", TransferCount, 0);
        for (int i = 0; i < 11; i++) tick();
        check("cnt_ten", TransferCount, 10);
        Reset = 1'b1;
        tick();
        check("cnt_cleared", TransferCount, 0);
        Reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
